// File: rtl/psum_acc_seq_if.sv
// Psum SRAM read-port bundle between the accumulation
// sequencer (master) and the psum memory (slave).
interface psum_acc_seq_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_w  = 11
);

  logic                     pmem_cen;
  logic [addr_w-1:0]        pmem_addr;
  logic [col*psum_bw-1:0]   pmem_q;

  modport master (
    output pmem_cen,
    output pmem_addr,
    input  pmem_q
  );

  modport slave (
    input  pmem_cen,
    input  pmem_addr,
    output pmem_q
  );

endinterface

// File: rtl/psum_acc_seq.sv
// Partial-sum accumulation sequencer: steps len_kij psum reads,
// accumulates full-width or per-lane with wrap/saturate and ReLU.
module psum_acc_seq #(
  parameter int col        = 8,
  parameter int psum_bw    = 16,
  parameter int lane_bw    = 8,
  parameter int len_kij    = 9,
  parameter int addr_w     = 11,
  parameter int kij_stride = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_w-1:0]      base_addr,
  input  logic                   simd_en,
  input  logic                   sat_en,
  input  logic                   relu_en,
  psum_acc_seq_if.master         pmem,
  output logic [col*psum_bw-1:0] acc_out,
  output logic                   acc_valid,
  output logic                   busy
);

  localparam int LANES = psum_bw / lane_bw;
  localparam int CNT_W = $clog2(len_kij + 1);
  localparam int ROW_W = col * psum_bw;

  localparam logic [addr_w-1:0] STRIDE =
    addr_w'(kij_stride);
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(len_kij - 1);

  localparam logic [psum_bw-1:0] FMAX =
    {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] FMIN =
    {1'b1, {(psum_bw-1){1'b0}}};
  localparam logic [lane_bw-1:0] LMAX =
    {1'b0, {(lane_bw-1){1'b1}}};
  localparam logic [lane_bw-1:0] LMIN =
    {1'b1, {(lane_bw-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic               w_accept;
  logic               w_add;
  logic               w_last;

  logic [CNT_W-1:0]   r_cnt;
  logic               r_cen;
  logic [addr_w-1:0]  r_addr;
  logic [ROW_W-1:0]   r_acc;
  logic [ROW_W-1:0]   r_out;
  logic               r_valid;
  logic               r_busy;
  logic               r_simd;
  logic               r_sat;
  logic               r_relu;

  logic [ROW_W-1:0]   w_sum;
  logic [ROW_W-1:0]   w_relu;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_add       = 1'b0;
    w_last      = (r_cnt == LAST_CNT);
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        // data for read r-1 is on pmem_q during read r
        w_add = (r_cnt != '0);
        if (w_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_add       = 1'b1;
        w_state_nxt = S_OUT;
      end
      S_OUT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_cen   <= 1'b1;
      r_addr  <= '0;
      r_acc   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_simd  <= 1'b0;
      r_sat   <= 1'b0;
      r_relu  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        r_cnt  <= '0;
        r_cen  <= 1'b0;
        r_addr <= base_addr;
        r_acc  <= '0;
        r_busy <= 1'b1;
        r_simd <= simd_en;
        r_sat  <= sat_en;
        r_relu <= relu_en;
      end else if (r_state == S_READ) begin
        if (w_last) begin
          r_cen <= 1'b1;
        end else begin
          r_cnt  <= r_cnt + CNT_W'(1);
          r_addr <= r_addr + STRIDE;
        end
      end
      if (w_add) begin
        r_acc <= w_sum;
      end
      if (r_state == S_OUT) begin
        r_out   <= w_relu;
        r_valid <= 1'b1;
      end
      // busy spans the acc_valid cycle, then falls
      if (r_state == S_IDLE && !start) begin
        r_busy <= 1'b0;
      end
    end
  end

  for (genvar c = 0; c < col; c++) begin : g_col
    localparam int B = c * psum_bw;

    logic [psum_bw-1:0] w_a;
    logic [psum_bw-1:0] w_b;
    logic [psum_bw:0]   w_fs;
    logic               w_fov;
    logic [psum_bw-1:0] w_full;
    logic [psum_bw-1:0] w_full_relu;
    logic [psum_bw-1:0] w_lsum;
    logic [psum_bw-1:0] w_lrelu;

    assign w_a = r_acc[B +: psum_bw];
    assign w_b = pmem.pmem_q[B +: psum_bw];

    assign w_fs =
      {w_a[psum_bw-1], w_a} +
      {w_b[psum_bw-1], w_b};
    assign w_fov =
      w_fs[psum_bw] ^ w_fs[psum_bw-1];
    assign w_full =
      (r_sat && w_fov) ?
      (w_fs[psum_bw] ? FMIN : FMAX) :
      w_fs[psum_bw-1:0];
    assign w_full_relu =
      w_a[psum_bw-1] ? '0 : w_a;

    // each lane sign-extends on its own; no carry crosses lanes
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      localparam int LB = l * lane_bw;

      logic [lane_bw-1:0] w_la;
      logic [lane_bw-1:0] w_lb;
      logic [lane_bw:0]   w_ls;
      logic               w_lov;

      assign w_la = w_a[LB +: lane_bw];
      assign w_lb = w_b[LB +: lane_bw];
      assign w_ls =
        {w_la[lane_bw-1], w_la} +
        {w_lb[lane_bw-1], w_lb};
      assign w_lov =
        w_ls[lane_bw] ^ w_ls[lane_bw-1];
      assign w_lsum[LB +: lane_bw] =
        (r_sat && w_lov) ?
        (w_ls[lane_bw] ? LMIN : LMAX) :
        w_ls[lane_bw-1:0];
      assign w_lrelu[LB +: lane_bw] =
        w_la[lane_bw-1] ? '0 : w_la;
    end

    assign w_sum[B +: psum_bw] =
      r_simd ? w_lsum : w_full;
    assign w_relu[B +: psum_bw] =
      !r_relu ? w_a :
      (r_simd ? w_lrelu : w_full_relu);
  end

  assign pmem.pmem_cen  = r_cen;
  assign pmem.pmem_addr = r_addr;
  assign acc_out        = r_out;
  assign acc_valid      = r_valid;
  assign busy           = r_busy;

endmodule
